// File: rtl/ceyloniac_operand_fetch.sv
// Ceyloniac decode/operand-fetch stage: splits the instruction, reads the regfile and registers the ID/EX bundle.
// Define CEYLONIAC_WB_BYPASS_EN to forward same-cycle write-back data; otherwise a matching write stalls one cycle.
module ceyloniac_operand_fetch #(
   parameter int unsigned REG_DATA_WIDTH = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               in_instr,
   input  logic [31:0]               in_pc,
   output logic [REG_ADDR_WIDTH-1:0] read_addr1,
   output logic [REG_ADDR_WIDTH-1:0] read_addr2,
   input  logic [REG_DATA_WIDTH-1:0] read_data1,
   input  logic [REG_DATA_WIDTH-1:0] read_data2,
   input  logic                      wb_write_enable,
   input  logic [REG_ADDR_WIDTH-1:0] wb_write_addr,
   input  logic [REG_DATA_WIDTH-1:0] wb_write_data,
   input  logic                      ex_load_valid,
   input  logic [REG_ADDR_WIDTH-1:0] ex_load_dest,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [5:0]                out_opcode,
   output logic [5:0]                out_funct,
   output logic [4:0]                out_shamt,
   output logic [REG_ADDR_WIDTH-1:0] out_rs_addr,
   output logic [REG_ADDR_WIDTH-1:0] out_rt_addr,
   output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
   output logic [REG_DATA_WIDTH-1:0] out_rs_data,
   output logic [REG_DATA_WIDTH-1:0] out_rt_data,
   output logic [31:0]               out_imm,
   output logic [31:0]               out_pc
);

   logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;
   logic [REG_DATA_WIDTH-1:0] rs_data, rt_data;
   logic [31:0]               imm;
   logic                      load_hazard, wb_hazard, stall, accept;

   logic                      out_valid_q, out_valid_d;
   logic [5:0]                opcode_q, opcode_d, funct_q, funct_d;
   logic [4:0]                shamt_q, shamt_d;
   logic [REG_ADDR_WIDTH-1:0] rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, rd_addr_q, rd_addr_d;
   logic [REG_DATA_WIDTH-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
   logic [31:0]               imm_q, imm_d, pc_q, pc_d;

   assign rs  = REG_ADDR_WIDTH'(in_instr[25:21]);
   assign rt  = REG_ADDR_WIDTH'(in_instr[20:16]);
   assign rd  = REG_ADDR_WIDTH'(in_instr[15:11]);
   assign imm = {{16{in_instr[15]}}, in_instr[15:0]};

   assign read_addr1 = rs;
   assign read_addr2 = rt;

   // Register 0 overrides both the regfile and any write-back to it.
   always_comb begin
      rs_data = read_data1;
      rt_data = read_data2;
`ifdef CEYLONIAC_WB_BYPASS_EN
      if (wb_write_enable && wb_write_addr == rs) rs_data = wb_write_data;
      if (wb_write_enable && wb_write_addr == rt) rt_data = wb_write_data;
`endif
      if (rs == '0) rs_data = '0;
      if (rt == '0) rt_data = '0;
   end

   assign load_hazard = ex_load_valid && (ex_load_dest != '0) &&
                        ((ex_load_dest == rs) || (ex_load_dest == rt));

`ifdef CEYLONIAC_WB_BYPASS_EN
   assign wb_hazard = 1'b0;
`else
   logic unused_wb_write_data;
   assign unused_wb_write_data = ^wb_write_data;
   assign wb_hazard = wb_write_enable && (wb_write_addr != '0) &&
                      ((wb_write_addr == rs) || (wb_write_addr == rt));
`endif

   assign stall    = in_valid && (load_hazard || wb_hazard);
   assign in_ready = !flush && !stall && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      opcode_d    = opcode_q;
      funct_d     = funct_q;
      shamt_d     = shamt_q;
      rs_addr_d   = rs_addr_q;
      rt_addr_d   = rt_addr_q;
      rd_addr_d   = rd_addr_q;
      rs_data_d   = rs_data_q;
      rt_data_d   = rt_data_q;
      imm_d       = imm_q;
      pc_d        = pc_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         opcode_d    = in_instr[31:26];
         funct_d     = in_instr[5:0];
         shamt_d     = in_instr[10:6];
         rs_addr_d   = rs;
         rt_addr_d   = rt;
         rd_addr_d   = rd;
         rs_data_d   = rs_data;
         rt_data_d   = rt_data;
         imm_d       = imm;
         pc_d        = in_pc;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         opcode_q    <= '0;
         funct_q     <= '0;
         shamt_q     <= '0;
         rs_addr_q   <= '0;
         rt_addr_q   <= '0;
         rd_addr_q   <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         opcode_q    <= opcode_d;
         funct_q     <= funct_d;
         shamt_q     <= shamt_d;
         rs_addr_q   <= rs_addr_d;
         rt_addr_q   <= rt_addr_d;
         rd_addr_q   <= rd_addr_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         imm_q       <= imm_d;
         pc_q        <= pc_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_opcode  = opcode_q;
   assign out_funct   = funct_q;
   assign out_shamt   = shamt_q;
   assign out_rs_addr = rs_addr_q;
   assign out_rt_addr = rt_addr_q;
   assign out_rd_addr = rd_addr_q;
   assign out_rs_data = rs_data_q;
   assign out_rt_data = rt_data_q;
   assign out_imm     = imm_q;
   assign out_pc      = pc_q;

endmodule

// File: tb/tb_ceyloniac_operand_fetch.sv
// Self-checking bench for ceyloniac_operand_fetch: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model with its own register file.
module tb_ceyloniac_operand_fetch;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready;
   logic [31:0] in_instr, in_pc;
   logic [4:0]  read_addr1, read_addr2;
   logic [31:0] read_data1, read_data2;
   logic        wb_write_enable;
   logic [4:0]  wb_write_addr;
   logic [31:0] wb_write_data;
   logic        ex_load_valid;
   logic [4:0]  ex_load_dest;
   logic        flush;
   logic        out_valid, out_ready;
   logic [5:0]  out_opcode, out_funct;
   logic [4:0]  out_shamt, out_rs_addr, out_rt_addr, out_rd_addr;
   logic [31:0] out_rs_data, out_rt_data, out_imm, out_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ceyloniac_operand_fetch dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_instr        (in_instr),
      .in_pc           (in_pc),
      .read_addr1      (read_addr1),
      .read_addr2      (read_addr2),
      .read_data1      (read_data1),
      .read_data2      (read_data2),
      .wb_write_enable (wb_write_enable),
      .wb_write_addr   (wb_write_addr),
      .wb_write_data   (wb_write_data),
      .ex_load_valid   (ex_load_valid),
      .ex_load_dest    (ex_load_dest),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_opcode      (out_opcode),
      .out_funct       (out_funct),
      .out_shamt       (out_shamt),
      .out_rs_addr     (out_rs_addr),
      .out_rt_addr     (out_rt_addr),
      .out_rd_addr     (out_rd_addr),
      .out_rs_data     (out_rs_data),
      .out_rt_data     (out_rt_data),
      .out_imm         (out_imm),
      .out_pc          (out_pc)
   );

   // Bench-owned register file; register 0 deliberately stores whatever is written to it.
   logic [31:0] regs [32];
   assign read_data1 = regs[read_addr1];
   assign read_data2 = regs[read_addr2];
   always @(posedge clk) if (wb_write_enable) regs[wb_write_addr] <= wb_write_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        exp_valid;
   logic [31:0] exp_instr, exp_rs, exp_rt, exp_pc;

   function automatic logic [31:0] m_operand(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
`ifdef CEYLONIAC_WB_BYPASS_EN
      if (wb_write_enable && wb_write_addr == idx) return wb_write_data;
`endif
      return regs[idx];
   endfunction

   function automatic logic m_uses(input logic [4:0] r);
      return (r != 5'd0) && (r == in_instr[25:21] || r == in_instr[20:16]);
   endfunction

   function automatic logic m_ready();
      logic blocked;
      blocked = ex_load_valid && m_uses(ex_load_dest);
`ifndef CEYLONIAC_WB_BYPASS_EN
      blocked = blocked || (wb_write_enable && m_uses(wb_write_addr));
`endif
      return !flush && !(in_valid && blocked) && (!exp_valid || out_ready);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_valid <= 1'b0;
         exp_instr <= '0;
         exp_rs    <= '0;
         exp_rt    <= '0;
         exp_pc    <= '0;
      end else if (in_valid && m_ready()) begin
         exp_valid <= 1'b1;
         exp_instr <= in_instr;
         exp_rs    <= m_operand(in_instr[25:21]);
         exp_rt    <= m_operand(in_instr[20:16]);
         exp_pc    <= in_pc;
      end else if (flush || out_ready) begin
         exp_valid <= 1'b0;
      end
   end

   // One compare per output, every cycle, mid-period.
   always @(negedge clk) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
      chk("read_addr1", {27'd0, read_addr1}, {27'd0, in_instr[25:21]});
      chk("read_addr2", {27'd0, read_addr2}, {27'd0, in_instr[20:16]});
      chk("out_opcode", {26'd0, out_opcode}, {26'd0, exp_instr[31:26]});
      chk("out_funct", {26'd0, out_funct}, {26'd0, exp_instr[5:0]});
      chk("out_shamt", {27'd0, out_shamt}, {27'd0, exp_instr[10:6]});
      chk("out_rs_addr", {27'd0, out_rs_addr}, {27'd0, exp_instr[25:21]});
      chk("out_rt_addr", {27'd0, out_rt_addr}, {27'd0, exp_instr[20:16]});
      chk("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, exp_instr[15:11]});
      chk("out_rs_data", out_rs_data, exp_rs);
      chk("out_rt_data", out_rt_data, exp_rt);
      chk("out_imm", out_imm, 32'($signed(exp_instr[15:0])));
      chk("out_pc", out_pc, exp_pc);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      in_valid = 1'b0; in_instr = '0; in_pc = '0;
      wb_write_enable = 1'b0; wb_write_addr = '0; wb_write_data = '0;
      ex_load_valid = 1'b0; ex_load_dest = '0;
      flush = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      reset_n = 1'b1;

      // Preload the regfile: reg i = 0x10000000 + i*0x111, then reg9 = 5, reg10 = 7.
      for (int i = 0; i < 32; i++) begin
         wb_write_enable = 1'b1; wb_write_addr = 5'(i); wb_write_data = 32'h1000_0000 + 32'(i) * 32'h111;
         tick();
      end
      wb_write_addr = 5'd9;  wb_write_data = 32'd5; tick();
      wb_write_addr = 5'd10; wb_write_data = 32'd7; tick();

      // add $8,$9,$10
      wb_write_enable = 1'b0;
      in_instr = 32'h012A_4020; in_pc = 32'h100; in_valid = 1'b1;
      #1 chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_rs", out_rs_data, 32'd5);
      chk("t1_rt", out_rt_data, 32'd7);
      chk("t1_rd", {27'd0, out_rd_addr}, 32'd8);
      chk("t1_funct", {26'd0, out_funct}, 32'h20);

      // Same-cycle write-back to rs.
      wb_write_enable = 1'b1; wb_write_addr = 5'd9; wb_write_data = 32'h55;
`ifdef CEYLONIAC_WB_BYPASS_EN
      #1 chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      wb_write_enable = 1'b0;
`else
      #1 chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      wb_write_enable = 1'b0;
      chk("t2_bubble", {31'd0, out_valid}, 32'd0);
      #1 chk("t2_retry_ready", {31'd0, in_ready}, 32'd1);
      tick();
`endif
      chk("t2_valid", {31'd0, out_valid}, 32'd1);
      chk("t2_rs", out_rs_data, 32'h55);

      // Load-use on $10.
      ex_load_valid = 1'b1; ex_load_dest = 5'd10;
      #1 chk("t3_stall_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("t3_bubble", {31'd0, out_valid}, 32'd0);
      ex_load_valid = 1'b0;
      #1 chk("t3_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("t3_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_rt", out_rt_data, 32'd7);

      // addi $8,$0,-1 while write-back targets reg 0.
      in_instr = 32'h2008_FFFF;
      wb_write_enable = 1'b1; wb_write_addr = 5'd0; wb_write_data = 32'h99;
      tick();
      wb_write_enable = 1'b0;
      chk("t4_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_rs_zero", out_rs_data, 32'd0);
      chk("t4_imm", out_imm, 32'hFFFF_FFFF);
      chk("t4_opcode", {26'd0, out_opcode}, 32'd8);
      chk("t4_rt_addr", {27'd0, out_rt_addr}, 32'd8);

      // Backpressure for three cycles, then release: sub $10,$8,$9 captured on release.
      out_ready = 1'b0; in_instr = 32'h0109_5022;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t5_hold_ready", {31'd0, in_ready}, 32'd0);
         tick();
         chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("t5_hold_imm", out_imm, 32'hFFFF_FFFF);
      end
      out_ready = 1'b1;
      #1 chk("t5_release_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("t5_rd", {27'd0, out_rd_addr}, 32'd10);
      chk("t5_rs", out_rs_data, 32'h1000_0888);
      chk("t5_rt", out_rt_data, 32'h55);
      chk("t5_imm", out_imm, 32'h5022);

      // Flush during an accept attempt.
      flush = 1'b1; in_instr = 32'h012A_4020;
      #1 chk("t6_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("t6_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_rd_hold", {27'd0, out_rd_addr}, 32'd10);

      // Asynchronous reset mid-stream; first accept on the first edge after release.
      in_valid = 1'b1; in_pc = 32'h400;
      #1 reset_n = 1'b0;
      #1 chk("t7_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("t7_rst_rd", {27'd0, out_rd_addr}, 32'd0);
      chk("t7_rst_pc", out_pc, 32'd0);
      tick();
      reset_n = 1'b1;
      #1 chk("t7_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("t7_valid", {31'd0, out_valid}, 32'd1);
      chk("t7_rs", out_rs_data, 32'h55);
      chk("t7_pc", out_pc, 32'h400);

      // Randomized traffic on a small register window to provoke hazards and bypasses.
      for (int i = 0; i < 3000; i++) begin
         in_valid        = ($urandom_range(3, 0) != 0);
         in_instr        = {6'($urandom), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                            16'($urandom)};
         in_pc           = $urandom;
         wb_write_enable = $urandom_range(1, 0) == 1;
         wb_write_addr   = 5'($urandom_range(3, 0));
         wb_write_data   = $urandom;
         ex_load_valid   = $urandom_range(2, 0) == 0;
         ex_load_dest    = 5'($urandom_range(3, 0));
         flush           = $urandom_range(15, 0) == 0;
         out_ready       = $urandom_range(3, 0) != 0;
         tick();
      end

      in_valid = 1'b0; wb_write_enable = 1'b0; ex_load_valid = 1'b0; flush = 1'b0;
      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ceyloniac_operand_fetch.md
# ceyloniac_operand_fetch

Decode/operand-fetch stage of the Ceyloniac pipeline, sitting between the IF/ID register and the execute stage. It splits the incoming 32-bit MIPS-format instruction into register indices and drives the register file read ports. It captures the returned operands, with write-back bypass and load-use hazard stalling, into a registered ID/EX bundle. Upstream and downstream are both coupled by valid/ready handshakes.

## Interface
- REG_DATA_WIDTH, 32, operand and write-back data width
- REG_ADDR_WIDTH, 5, register index width (fixed to instruction fields 25:21, 20:16, 15:11)
- clk  in  1  single clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction word valid from IF/ID
- in_ready  out  1  stage accepts in_instr/in_pc this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- read_addr1  out  REG_ADDR_WIDTH  regfile port 1 index, combinational = in_instr[25:21]
- read_addr2  out  REG_ADDR_WIDTH  regfile port 2 index, combinational = in_instr[20:16]
- read_data1  in  REG_DATA_WIDTH  regfile port 1 data
- read_data2  in  REG_DATA_WIDTH  regfile port 2 data
- wb_write_enable  in  1  write-back stage writes the regfile at next posedge
- wb_write_addr  in  REG_ADDR_WIDTH  write-back destination
- wb_write_data  in  REG_DATA_WIDTH  write-back value
- ex_load_valid  in  1  execute stage holds a load
- ex_load_dest  in  REG_ADDR_WIDTH  that load's destination register
- flush  in  1  synchronous pipeline kill (branch or jump redirect)
- out_valid  out  1  ID/EX bundle valid
- out_ready  in  1  execute stage accepts bundle
- out_opcode  out  6  instr[31:26]
- out_funct  out  6  instr[5:0]
- out_shamt  out  5  instr[10:6]
- out_rs_addr, out_rt_addr, out_rd_addr  out  REG_ADDR_WIDTH each  instruction fields
- out_rs_data, out_rt_data  out  REG_DATA_WIDTH each  resolved operands
- out_imm  out  32  instr[15:0] sign-extended
- out_pc  out  32  captured in_pc

## Operation
- Operand resolution, per operand, evaluated in priority order:
  - Index 0 resolves to 0, regardless of the regfile or bypass.
  - If bypass is compiled in and wb_write_enable && wb_write_addr == index, the operand is wb_write_data.
  - Otherwise the operand is the regfile read data.
- Load-use hazard = ex_load_valid && ex_load_dest != 0 && (ex_load_dest == rs || ex_load_dest == rt). rt is checked for every opcode.
- stall = in_valid && hazard (plus the write-back stall when bypass is compiled out; see Configuration).
- in_ready = !stall && (!out_valid || out_ready).
- accept = in_valid && in_ready. On accept, all out_* fields load from the decoded instruction and resolved operands, and out_valid <= 1.
- If out_valid && out_ready && !accept, out_valid <= 0 (bubble). The data fields hold their values.
- A stall injects a bubble only. The held instruction is re-evaluated every cycle until accepted.
- flush has the highest priority: out_valid <= 0 and nothing is accepted that cycle. in_ready is forced to 0 while flush is high.

## Timing
- Reset (reset_n low, asynchronous): out_valid = 0 and every out_* data field = 0. in_ready follows its combinational equation (1 when in_valid = 0).
- Decode-to-output latency is 1 cycle. The bundle is visible the cycle after accept.
- Operands are sampled in the accept cycle. The regfile is combinational-read and written at posedge, so a same-cycle write must be bypassed or stalled.
- Throughput is 1 instruction/cycle with no hazards and out_ready held at 1.
- If out_valid && !out_ready, all outputs hold stable and in_ready = 0.
- Simultaneous wb write and load hazard on the same register: the stall wins and no capture occurs. The bypassed or updated value is used on the next try.
- reset_n deassertion mid-stream: the first accept can occur on the first posedge after release.

## Configuration
- CEYLONIAC_WB_BYPASS_EN defined: same-cycle write-back data is forwarded into the operands as described in Operation.
- CEYLONIAC_WB_BYPASS_EN undefined: no forwarding. The stall condition also includes in_valid && wb_write_enable && wb_write_addr != 0 && wb_write_addr ∈ {rs, rt}. This costs one stall cycle, after which the regfile returns the written value.

## Test plan
- Reset, then in_instr = 0x012A4020 (add $8,$9,$10) with reg9 = 5, reg10 = 7 -> next cycle out_valid = 1, out_rs_data = 5, out_rt_data = 7, out_rd_addr = 8.
- Same instruction with wb_write_enable = 1, wb_write_addr = 9, wb_write_data = 0x55 in the accept cycle -> out_rs_data = 0x55 (bypass) or one stall cycle then 0x55 (no bypass).
- ex_load_valid = 1, ex_load_dest = 10, then instruction using $10 -> in_ready = 0 for 1 cycle with out_valid = 0 bubble. Accepted the cycle after ex_load_valid drops.
- in_instr = 0x2008FFFF (addi $8,$0,-1) with wb writing reg 0 = 0x99 -> out_rs_data = 0, out_imm = 0xFFFFFFFF.
- out_ready = 0 for 3 cycles with a valid bundle -> outputs stable and in_ready = 0. Release -> the next instruction is captured the same cycle.
- flush during accept of 0x012A4020 -> next cycle out_valid = 0 and the instruction is not captured.
